// File: rtl/waveform_average_mc.sv
// Multi-channel triggered waveform averager: accumulates records into block RAM
// with saturating signed sums, then streams scaled sums over a valid/ready port.
module waveform_average_mc #(
  parameter int NofParallellSamples = 4,
  parameter int NofChannels         = 2,
  parameter int BitsIn              = 16,
  parameter int BitsOut             = 32,
  parameter int AddressWidth        = 10
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [NofChannels*NofParallellSamples*BitsIn-1:0] x_i,
  input  logic                                              data_valid_i,
  input  logic                                              trigger_i,
  input  logic                                              arm_i,
  input  logic                                              abort_i,
  input  logic [15:0]                                       NofSampleCycles_i,
  input  logic [15:0]                                       NofWaveforms_i,
  input  logic [15:0]                                       NofHoldoffCycles_i,
  input  logic [4:0]                                        shift_i,
  output logic [NofChannels*NofParallellSamples*BitsOut-1:0] y_o,
  output logic                                              y_valid_o,
  input  logic                                              y_ready_i,
  output logic                                              y_last_o,
  output logic                                              in_idle_o,
  output logic                                              data_available_o,
  output logic [15:0]                                       records_collected_o,
  output logic                                              overflow_o
);
  localparam int Lanes = NofChannels * NofParallellSamples;
  localparam int Depth = 1 << AddressWidth;
  localparam int WordW = Lanes * BitsOut;
  localparam logic [AddressWidth:0] AOne   = (AddressWidth+1)'(1);
  localparam logic [AddressWidth:0] ADepth = (AddressWidth+1)'(Depth);

  typedef enum logic [2:0] {IDLE, WAIT_TRIG, COLLECT, HOLDOFF, READOUT} state_t;
  state_t state_q, state_d;

  logic [AddressWidth:0] ncyc_q, ncyc_d, addr_q, addr_d, last_addr;
  logic [15:0]           nwave_q, nwave_d, holdoff_q, holdoff_d;
  logic [15:0]           hold_q, hold_d, rec_q, rec_d;
  logic [4:0]            shift_q, shift_d;
  logic                  ovf_q, ovf_d, in_idle_q, avail_q;
  logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                  y_valid_q, y_valid_d, y_last_q, y_last_d;
  logic [WordW-1:0]      y_q, y_d;

  logic                     wr_en_q, first_q;
  logic [AddressWidth-1:0]  wr_addr_q;
  logic [Lanes*BitsIn-1:0]  x_q;
  logic [WordW-1:0]         ram_rd_q, wr_data, y_shift;
  logic [Lanes-1:0]         sat_vec;
  logic [WordW-1:0]         mem [Depth];

  logic trig_acc, col_acc, acc, rec_end, out_adv, rd_adv, rd_issue, ram_re;

  assign last_addr = ncyc_q - AOne;
  assign trig_acc  = (state_q == WAIT_TRIG) && trigger_i && data_valid_i && !abort_i;
  assign col_acc   = (state_q == COLLECT) && data_valid_i && !abort_i;
  assign acc       = trig_acc || col_acc;
  // addr_q is 0 in WAIT_TRIG, so a one-cycle record ends on the trigger itself
  assign rec_end   = acc && (addr_q == last_addr);
  assign out_adv   = !y_valid_q || y_ready_i;
  assign rd_adv    = !rd_valid_q || out_adv;
  assign rd_issue  = (state_q == READOUT) && rd_adv && (addr_q < ncyc_q) && !abort_i;
  assign ram_re    = acc || rd_issue;

  for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
    logic signed [BitsOut-1:0] acc_l, x_l;
    logic [BitsOut:0]          sum_l;
    logic                      sat_l;
    assign acc_l = ram_rd_q[gi*BitsOut +: BitsOut];
    assign x_l   = BitsOut'($signed(x_q[gi*BitsIn +: BitsIn]));
    assign sum_l = {acc_l[BitsOut-1], acc_l} + {x_l[BitsOut-1], x_l};
    assign sat_l = sum_l[BitsOut] ^ sum_l[BitsOut-1];
    assign sat_vec[gi] = sat_l && !first_q;
    assign wr_data[gi*BitsOut +: BitsOut] =
        first_q ? x_l :
        !sat_l  ? sum_l[BitsOut-1:0] :
        sum_l[BitsOut] ? {1'b1, {(BitsOut-1){1'b0}}} : {1'b0, {(BitsOut-1){1'b1}}};
    assign y_shift[gi*BitsOut +: BitsOut] = acc_l >>> shift_q;
  end

  always_comb begin
    state_d    = state_q;
    ncyc_d     = ncyc_q;
    nwave_d    = nwave_q;
    holdoff_d  = holdoff_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    rec_d      = rec_q;
    ovf_d      = ovf_q || (wr_en_q && (|sat_vec));
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    y_valid_d  = y_valid_q;
    y_last_d   = y_last_q;
    y_d        = y_q;
    unique case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = WAIT_TRIG;
          if (NofSampleCycles_i == 16'd0)                 ncyc_d = AOne;
          else if ({1'b0, NofSampleCycles_i} > 17'(Depth)) ncyc_d = ADepth;
          else                                             ncyc_d = NofSampleCycles_i[AddressWidth:0];
          nwave_d   = (NofWaveforms_i == 16'd0) ? 16'd1 : NofWaveforms_i;
          holdoff_d = NofHoldoffCycles_i;
          shift_d   = shift_i;
          rec_d     = '0;
          ovf_d     = 1'b0;
          addr_d    = '0;
        end
      end
      WAIT_TRIG, COLLECT: begin
        if (acc) begin
          state_d = COLLECT;
          addr_d  = addr_q + AOne;
          if (rec_end) begin
            state_d = HOLDOFF;
            addr_d  = '0;
            rec_d   = rec_q + 16'd1;
            // at least one gap cycle so the last write lands before address 0 is re-read
            if (rec_q + 16'd1 < nwave_q)
              hold_d = (holdoff_q == 16'd0) ? 16'd0 : holdoff_q - 16'd1;
            else
              hold_d = 16'd0;
          end
        end
      end
      HOLDOFF: begin
        if (hold_q == 16'd0) state_d = (rec_q < nwave_q) ? WAIT_TRIG : READOUT;
        else                 hold_d  = hold_q - 16'd1;
      end
      READOUT: begin
        if (out_adv) begin
          y_valid_d = rd_valid_q;
          y_last_d  = rd_last_q;
          if (rd_valid_q) y_d = y_shift;
        end
        if (rd_adv) begin
          rd_valid_d = rd_issue;
          rd_last_d  = (addr_q == last_addr);
        end
        if (rd_issue) addr_d = addr_q + AOne;
        if (y_valid_q && y_ready_i && y_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d    = IDLE;
      addr_d     = '0;
      ovf_d      = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      y_valid_d  = 1'b0;
      y_last_d   = 1'b0;
      y_d        = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ncyc_q     <= AOne;
      nwave_q    <= 16'd1;
      holdoff_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      hold_q     <= '0;
      rec_q      <= '0;
      ovf_q      <= 1'b0;
      in_idle_q  <= 1'b1;
      avail_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      y_last_q   <= 1'b0;
      y_q        <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ncyc_q     <= ncyc_d;
      nwave_q    <= nwave_d;
      holdoff_q  <= holdoff_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      rec_q      <= rec_d;
      ovf_q      <= ovf_d;
      in_idle_q  <= (state_d == IDLE);
      avail_q    <= (state_d == READOUT);
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      y_valid_q  <= y_valid_d;
      y_last_q   <= y_last_d;
      y_q        <= y_d;
      wr_en_q    <= acc;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_addr_q <= addr_q[AddressWidth-1:0];
    x_q       <= x_i;
    first_q   <= (rec_q == 16'd0);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data;
    if (ram_re)  ram_rd_q <= mem[addr_q[AddressWidth-1:0]];
  end

  assign y_o                 = y_q;
  assign y_valid_o           = y_valid_q;
  assign y_last_o            = y_last_q;
  assign in_idle_o           = in_idle_q;
  assign data_available_o    = avail_q;
  assign records_collected_o = rec_q;
  assign overflow_o          = ovf_q;
endmodule

// File: tb/tb_waveform_average_mc.sv
// Directed bench for waveform_average_mc: averaging, gaps, saturation,
// backpressure, edge configs, abort and reset.
module tb_waveform_average_mc;
  localparam int P  = 4;
  localparam int C  = 2;
  localparam int BI = 16;
  localparam int BO = 17;
  localparam int AW = 4;
  localparam int NL = P * C;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NL*BI-1:0]  x_i;
  logic              data_valid_i, trigger_i, arm_i, abort_i;
  logic [15:0]       NofSampleCycles_i, NofWaveforms_i, NofHoldoffCycles_i;
  logic [4:0]        shift_i;
  logic [NL*BO-1:0]  y_o;
  logic              y_valid_o, y_ready_i, y_last_o, in_idle_o, data_available_o, overflow_o;
  logic [15:0]       records_collected_o;

  waveform_average_mc #(
    .NofParallellSamples(P), .NofChannels(C), .BitsIn(BI), .BitsOut(BO), .AddressWidth(AW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .x_i(x_i), .data_valid_i(data_valid_i),
    .trigger_i(trigger_i), .arm_i(arm_i), .abort_i(abort_i),
    .NofSampleCycles_i(NofSampleCycles_i), .NofWaveforms_i(NofWaveforms_i),
    .NofHoldoffCycles_i(NofHoldoffCycles_i), .shift_i(shift_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_last_o(y_last_o),
    .in_idle_o(in_idle_o), .data_available_o(data_available_o),
    .records_collected_o(records_collected_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int got [0:63][0:NL-1];
  int gotlast [0:63];
  int nwords;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int lane(input int l);
    logic signed [BO-1:0] t;
    t = y_o[l*BO +: BO];
    return int'(t);
  endfunction

  function automatic logic [NL*BI-1:0] mkx(input int a, input int b);
    logic [NL*BI-1:0] v;
    v = '0;
    for (int s = 0; s < P; s++) begin
      v[s*BI +: BI]     = BI'(a);
      v[(P+s)*BI +: BI] = BI'(b);
    end
    return v;
  endfunction

  task automatic arm(input int n, input int w, input int h, input int sh);
    NofSampleCycles_i  = 16'(n);
    NofWaveforms_i     = 16'(w);
    NofHoldoffCycles_i = 16'(h);
    shift_i            = 5'(sh);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  // one record: trigger on the first valid cycle; value per cycle is base + step*k
  task automatic record(input int n, input int a, input int b, input int da, input int db,
                        input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) begin
        data_valid_i = 1'b0;
        trigger_i    = 1'b0;
        x_i          = mkx(31000, 31000);
        tick();
      end
      data_valid_i = 1'b1;
      trigger_i    = (k == 0);
      x_i          = mkx(a + da*k, b + db*k);
      tick();
    end
    data_valid_i = 1'b0;
    trigger_i    = 1'b0;
  endtask

  task automatic readout(input bit rnd);
    int  budget;
    bit  done;
    budget = 400;
    done   = 1'b0;
    nwords = 0;
    while (!done && budget > 0) begin
      y_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (y_valid_o && y_ready_i && nwords < 64) begin
        for (int l = 0; l < NL; l++) got[nwords][l] = lane(l);
        gotlast[nwords] = int'(y_last_o);
        nwords++;
        if (y_last_o) done = 1'b1;
      end
      tick();
      budget--;
    end
    y_ready_i = 1'b0;
    chk("readout_done", int'(done), 1);
  endtask

  task automatic check_words(input string tag, input int n, input int a, input int b,
                             input int da, input int db);
    int e;
    chk($sformatf("%s_count", tag), nwords, n);
    for (int w = 0; w < n && w < nwords; w++) begin
      for (int l = 0; l < NL; l++) begin
        e = (l < P) ? a + da*w : b + db*w;
        chk($sformatf("%s_w%0d_l%0d", tag, w, l), got[w][l], e);
      end
      chk($sformatf("%s_last%0d", tag, w), gotlast[w], (w == n-1) ? 1 : 0);
    end
  endtask

  task automatic wait_valid(input string tag);
    int b;
    b = 0;
    y_ready_i = 1'b0;
    while (!y_valid_o && b < 60) begin
      tick();
      b++;
    end
    chk(tag, int'(y_valid_o), 1);
  endtask

  task automatic check_idle(input string tag, input int recs);
    chk({tag, "_idle"}, int'(in_idle_o), 1);
    chk({tag, "_avail"}, int'(data_available_o), 0);
    chk({tag, "_valid"}, int'(y_valid_o), 0);
    chk({tag, "_last"}, int'(y_last_o), 0);
    chk({tag, "_y"}, int'(|y_o), 0);
    chk({tag, "_ovf"}, int'(overflow_o), 0);
    chk({tag, "_recs"}, int'(records_collected_o), recs);
  endtask

  initial begin
    rst_i = 1'b1; x_i = '0; data_valid_i = 1'b0; trigger_i = 1'b0; arm_i = 1'b0;
    abort_i = 1'b0; y_ready_i = 1'b0; shift_i = '0;
    NofSampleCycles_i = '0; NofWaveforms_i = '0; NofHoldoffCycles_i = '0;
    repeat (3) tick();
    check_idle("reset", 0);
    rst_i = 1'b0;
    tick();

    // basic average: triggers 10 cycles apart
    arm(4, 3, 5, 0);
    chk("arm_not_idle", int'(in_idle_o), 0);
    for (int r = 0; r < 3; r++) begin
      record(4, 100, -7, 0, 0, 1'b0);
      repeat (6) tick();
    end
    readout(1'b0);
    check_words("basic", 4, 300, -21, 0, 0);
    chk("basic_recs", int'(records_collected_o), 3);
    chk("basic_idle_after", int'(in_idle_o), 1);
    chk("basic_avail_after", int'(data_available_o), 0);

    // valid gaps, stray triggers inside holdoff
    arm(4, 3, 5, 0);
    for (int r = 0; r < 3; r++) begin
      record(4, 100, -7, 0, 0, 1'b1);
      tick();
      trigger_i = 1'b1; data_valid_i = 1'b1; x_i = mkx(5000, 5000);
      tick();
      trigger_i = 1'b0; data_valid_i = 1'b0;
      repeat (4) tick();
    end
    readout(1'b0);
    check_words("gaps", 4, 300, -21, 0, 0);
    chk("gaps_recs", int'(records_collected_o), 3);

    // saturation both directions
    arm(2, 4, 1, 0);
    for (int r = 0; r < 4; r++) begin
      record(2, 32767, -32768, 0, 0, 1'b0);
      repeat (2) tick();
    end
    readout(1'b0);
    check_words("sat", 2, 65535, -65536, 0, 0);
    chk("sat_ovf", int'(overflow_o), 1);

    // backpressure with ramp and shift
    arm(6, 2, 1, 1);
    chk("bp_ovf_cleared", int'(overflow_o), 0);
    for (int r = 0; r < 2; r++) begin
      record(6, 0, 0, 1, -1, 1'b0);
      repeat (2) tick();
    end
    readout(1'b1);
    check_words("bp", 6, 0, 0, 1, -1);

    // N=0 and W=0 clamp to 1
    arm(0, 0, 0, 0);
    record(1, 100, -7, 0, 0, 1'b0);
    readout(1'b0);
    check_words("n0", 1, 100, -7, 0, 0);
    chk("n0_recs", int'(records_collected_o), 1);

    // N above RAM depth clamps to 16
    arm(100, 1, 0, 0);
    record(16, 0, 0, 1, -1, 1'b0);
    readout(1'b0);
    check_words("nclamp", 16, 0, 0, 1, -1);

    // N=1, holdoff 0, trigger held high: accepts every other cycle
    arm(1, 3, 0, 0);
    for (int j = 0; j < 5; j++) begin
      trigger_i = 1'b1; data_valid_i = 1'b1;
      x_i = (j % 2 == 0) ? mkx(10 + j/2, -(10 + j/2)) : mkx(1000, -1000);
      tick();
    end
    trigger_i = 1'b0; data_valid_i = 1'b0;
    readout(1'b0);
    check_words("b2b", 1, 33, -33, 0, 0);
    chk("b2b_recs", int'(records_collected_o), 3);

    // abort mid-COLLECT keeps record count
    arm(4, 2, 3, 0);
    record(4, 1, 2, 0, 0, 1'b0);
    repeat (4) tick();
    trigger_i = 1'b1; data_valid_i = 1'b1; x_i = mkx(1, 2);
    tick();
    trigger_i = 1'b0;
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0; data_valid_i = 1'b0;
    check_idle("abort_col", 1);

    // abort mid-READOUT
    arm(4, 2, 1, 0);
    record(4, 1, 2, 0, 0, 1'b0);
    repeat (2) tick();
    record(4, 1, 2, 0, 0, 1'b0);
    wait_valid("ab_ro_valid");
    chk("ab_ro_avail", int'(data_available_o), 1);
    chk("ab_ro_w0", lane(0), 2);
    tick();
    chk("ab_ro_hold_valid", int'(y_valid_o), 1);
    chk("ab_ro_hold_ch1", lane(P), 4);
    y_ready_i = 1'b1;
    tick();
    y_ready_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_idle("abort_ro", 2);

    // reset mid-READOUT
    arm(2, 1, 0, 0);
    record(2, 7, 8, 0, 0, 1'b0);
    wait_valid("rst_ro_valid");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle("rst_ro", 0);
    tick();

    // fresh run after abort/reset
    arm(3, 2, 1, 0);
    for (int r = 0; r < 2; r++) begin
      record(3, 5, -3, 0, 0, 1'b0);
      repeat (2) tick();
    end
    readout(1'b0);
    check_words("fresh", 3, 10, -6, 0, 0);
    chk("fresh_recs", int'(records_collected_o), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/waveform_average_mc.md
# waveform_average_mc

Multi-channel, parametrised successor to the four-sample waveform averager. Accumulates `NofWaveforms` triggered records of `NofSampleCycles` parallel-sample cycles per channel into internal block RAM with saturating signed arithmetic. It then streams the scaled sums out through a valid/ready port. The block sits between the ADC sample pipeline (after level-trigger and sample-skip) and the readout FIFO.

## Interface
- `NofParallellSamples`, default 4: samples per channel per clock.
- `NofChannels`, default 2: independent input channels sharing trigger and control.
- `BitsIn`, default 16: signed input sample width.
- `BitsOut`, default 32: signed accumulator and output width per sample.
- `AddressWidth`, default 10: RAM depth of 2^AddressWidth sample cycles per record.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `x_i`  in  NofChannels*NofParallellSamples*BitsIn  samples; channel c, sample s at index (c*NofParallellSamples+s)*BitsIn.
- `data_valid_i`  in  1  `x_i` valid this cycle.
- `trigger_i`  in  1  record trigger, qualified by `data_valid_i`.
- `arm_i`  in  1  one-cycle pulse; starts an averaging run from IDLE.
- `abort_i`  in  1  one-cycle pulse; returns to IDLE.
- `NofSampleCycles_i`  in  16  sample cycles per record.
- `NofWaveforms_i`  in  16  records to accumulate.
- `NofHoldoffCycles_i`  in  16  clocks after a record during which triggers are ignored.
- `shift_i`  in  5  arithmetic right shift applied to sums on readout.
- `y_o`  out  NofChannels*NofParallellSamples*BitsOut  scaled sums, same packing as `x_i`.
- `y_valid_o`  out  1  `y_o` valid.
- `y_ready_i`  in  1  downstream accepts `y_o`.
- `y_last_o`  out  1  final word of the readout.
- `in_idle_o`  out  1  FSM in IDLE.
- `data_available_o`  out  1  readout in progress.
- `records_collected_o`  out  16  records accumulated in the current run.
- `overflow_o`  out  1  sticky; any accumulator saturated during the run.

## Operation
- **Reset values:** `y_o`=0, `y_valid_o`=0, `y_last_o`=0, `in_idle_o`=1, `data_available_o`=0, `records_collected_o`=0, `overflow_o`=0, FSM=IDLE.
- **States:** IDLE, WAIT_TRIG, COLLECT, HOLDOFF, READOUT.
- **IDLE → WAIT_TRIG** on `arm_i`. Arming latches the config inputs, clears `records_collected_o` and `overflow_o`, and clamps the latched values:
  - NofSampleCycles: 0 → 1; values above 2^AddressWidth → 2^AddressWidth.
  - NofWaveforms: 0 → 1.
- `arm_i` is ignored outside IDLE.
- **WAIT_TRIG → COLLECT** when `trigger_i` and `data_valid_i` are both high. The trigger cycle's data is sample cycle 0.
- **COLLECT:** each cycle with `data_valid_i` high reads RAM[addr] and writes back the sum. Cycles with `data_valid_i` low stall the address counter.
  - Record 0 writes the sign-extended input, ignoring RAM contents.
  - Later records write the saturating sum of RAM and input, clamped to [-2^(BitsOut-1), 2^(BitsOut-1)-1]. Saturation sets `overflow_o`.
- **COLLECT → HOLDOFF** after the last sample cycle is accepted. `records_collected_o` increments on this transition.
- **HOLDOFF** length:
  - If records < NofWaveforms: max(1, NofHoldoffCycles) clocks, then → WAIT_TRIG.
  - Otherwise: exactly 1 clock, then → READOUT.
  - The minimum one-cycle gap guarantees the final write completes before the next read of address 0. Triggers in HOLDOFF are ignored.
- **READOUT:** streams addresses 0..NofSampleCycles-1. Each `y_o` lane equals sum >>> `shift_i` (arithmetic shift), truncated to BitsOut.
  - `y_o` holds while `y_valid_o && !y_ready_i`.
  - `y_last_o` accompanies the final word.
  - After the last handshake → IDLE; `data_available_o` falls and `records_collected_o` holds its value until the next arm.
- **`abort_i`** in any state → IDLE next cycle with `y_valid_o`=0 and `data_available_o`=0. RAM contents become don't-care.
- **Simultaneous events:** `abort_i` has priority over `arm_i` and over trigger. A trigger coincident with the last HOLDOFF cycle is ignored.

## Timing
- The RAM has a one-cycle read latency. Input data is pipelined one stage, so an accumulate read in cycle t is written in t+1.
- A trigger in cycle t puts the FSM in COLLECT at t+1 (addresses 1..). With N=1 and a single valid cycle, the FSM enters HOLDOFF at t+1.
- Earliest next trigger acceptance is 2 clocks after COLLECT ends.
- First `y_valid_o` comes 2 clocks after entering READOUT. With `y_ready_i` held high, throughput is one word per clock with no bubbles. Deasserting ready must not lose or duplicate words.
- `in_idle_o` and `data_available_o` are registered and reflect the state one clock after each transition.

## Test plan
- **Basic average:** NofChannels=2, N=4, W=3, shift=0, constant input 100 on ch0 and -7 on ch1, triggers spaced 10 cycles. Expect 4 words, ch0 lanes 300, ch1 lanes -21, `y_last_o` on word 4, `records_collected_o`=3.
- **Valid gaps and holdoff:** `data_valid_i` toggling every cycle during COLLECT, holdoff=5, trigger pulses at 2 clocks after record end. Expect those triggers ignored, sums identical to the gap-free run.
- **Saturation:** input 32767, BitsOut=17, W=4. Expect lanes clamp to 65535 and `overflow_o`=1 until next arm.
- **Backpressure:** ramp input 0..N-1, `y_ready_i` random 50%, shift=1, W=2. Expect exactly N words, each equal to the ramp index (2k>>>1), in order, with no duplicates.
- **Edge configs:** N=0 → 1 word; W=0 → 1 record; N=1 with holdoff=0 and back-to-back triggers → each record added exactly once.
- **Abort and reset:** abort mid-COLLECT and mid-READOUT, and `rst_i` mid-READOUT. Expect IDLE next cycle, all outputs at reset values (abort keeps `records_collected_o`), and a subsequent arm producing correct fresh results.
